// File: rtl/complex_result_reader_pkg.sv
// ============================================================================
// Module   : complex_result_reader_pkg
// Brief    : Shared widths, complex word type and drain FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package complex_result_reader_pkg;

    localparam int c_ew_default      = 64;
    localparam int c_n_words_default = 8;

    // One complex single-precision word: real half in the upper bits.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/complex_result_slot.sv
// ============================================================================
// Module   : complex_result_slot
// Brief    : One result-vector storage slot with full flag and word-select mux.
// Config   : COMPLEX_READER_ZERO_SKIP_EN adds a per-word non-zero mask output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_result_slot
    import complex_result_reader_pkg::*;
#(
    parameter int EW      = c_ew_default,
    parameter int N_WORDS = c_n_words_default
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         clr,
    input  logic [EW*N_WORDS-1:0]        wr_data,
    input  logic [$clog2(N_WORDS)-1:0]   sel,
    output logic                         full,
    output logic [EW-1:0]                rd_word
`ifdef COMPLEX_READER_ZERO_SKIP_EN
    ,
    output logic [N_WORDS-1:0]           nz_mask
`endif
);

    localparam int                c_idx_w   = $clog2(N_WORDS);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(N_WORDS - 1);

    logic                         r_full;
    logic [N_WORDS-1:0][EW-1:0]   r_data;

    // A write wins over a clear so a slot freed on its last word can refill at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (wr_en) begin
            r_full <= 1'b1;
        end else if (clr) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_data <= wr_data;
        end
    end

    assign full    = r_full;
    assign rd_word = r_data[c_idx_max - sel];

`ifdef COMPLEX_READER_ZERO_SKIP_EN
    for (genvar k = 0; k < N_WORDS; k++) begin : g_nz
        assign nz_mask[k] = |r_data[N_WORDS-1-k];
    end
`endif

endmodule

`default_nettype wire

// File: rtl/complex_result_reader.sv
// ============================================================================
// Module   : complex_result_reader
// Brief    : Captures packed result vectors into a ping-pong buffer and drains
//            them MSB word first over a valid/ready stream.
// Config   : COMPLEX_READER_ZERO_SKIP_EN - skip all-zero complex words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_result_reader
    import complex_result_reader_pkg::*;
#(
    parameter int EW      = c_ew_default,
    parameter int N_WORDS = c_n_words_default
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  outsider_read_now,
    input  logic [EW*N_WORDS-1:0] result_in,
    output logic [EW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overflow
);

    localparam int                 c_idx_w   = $clog2(N_WORDS);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(N_WORDS - 1);

    drain_state_t         r_state;
    logic                 r_wp;
    logic                 r_rp;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_overflow;

    logic [1:0]           w_full;
    logic [1:0]           w_wr;
    logic [1:0]           w_clr;
    logic [EW-1:0]        w_word [2];
    logic                 w_hs;
    logic                 w_last_hs;
    logic                 w_capture;
    logic [c_idx_w-1:0]   w_first_rp;
    logic [c_idx_w-1:0]   w_first_other;
    logic [c_idx_w-1:0]   w_next_idx;
    logic [c_idx_w-1:0]   w_last_idx;

`ifdef COMPLEX_READER_ZERO_SKIP_EN
    logic [1:0][N_WORDS-1:0] w_nz;

    // An all-zero vector resolves first and last to word 0, emitting one zero word.
    function automatic logic [c_idx_w-1:0] first_nz(input logic [N_WORDS-1:0] m);
        first_nz = '0;
        for (int k = N_WORDS - 1; k >= 0; k--) begin
            if (m[k]) first_nz = c_idx_w'(k);
        end
    endfunction

    function automatic logic [c_idx_w-1:0] last_nz(input logic [N_WORDS-1:0] m);
        last_nz = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (m[k]) last_nz = c_idx_w'(k);
        end
    endfunction

    function automatic logic [c_idx_w-1:0] next_nz(input logic [N_WORDS-1:0] m,
                                                   input logic [c_idx_w-1:0] cur);
        next_nz = cur;
        for (int k = N_WORDS - 1; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) next_nz = c_idx_w'(k);
        end
    endfunction
`endif

    for (genvar s = 0; s < 2; s++) begin : g_slot
        assign w_wr[s]  = w_capture & (r_wp == 1'(s));
        assign w_clr[s] = w_last_hs & (r_rp == 1'(s));

        complex_result_slot #(
            .EW      (EW),
            .N_WORDS (N_WORDS)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (w_wr[s]),
            .clr     (w_clr[s]),
            .wr_data (result_in),
            .sel     (r_idx),
            .full    (w_full[s]),
            .rd_word (w_word[s])
`ifdef COMPLEX_READER_ZERO_SKIP_EN
            ,
            .nz_mask (w_nz[s])
`endif
        );
    end

    always_comb begin
`ifdef COMPLEX_READER_ZERO_SKIP_EN
        w_first_rp    = first_nz(w_nz[r_rp]);
        w_first_other = first_nz(w_nz[~r_rp]);
        w_next_idx    = next_nz(w_nz[r_rp], r_idx);
        w_last_idx    = last_nz(w_nz[r_rp]);
`else
        w_first_rp    = '0;
        w_first_other = '0;
        w_next_idx    = r_idx + 1'b1;
        w_last_idx    = c_idx_max;
`endif
    end

    assign w_hs      = out_valid & out_ready;
    assign w_last_hs = w_hs & (r_idx == w_last_idx);
    // The slot being released this cycle counts as free for an incoming strobe.
    assign w_capture = outsider_read_now &
                       (~w_full[r_wp] | (w_last_hs & (r_wp == r_rp)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wp <= ~r_wp;
            end else if (outsider_read_now) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_full[r_rp]) begin
                        r_state <= ST_SEND;
                        r_idx   <= w_first_rp;
                    end
                end
                ST_SEND: begin
                    if (w_last_hs) begin
                        r_rp <= ~r_rp;
                        if (w_full[~r_rp]) begin
                            r_idx <= w_first_other;
                        end else begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                        end
                    end else if (w_hs) begin
                        r_idx <= w_next_idx;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == ST_SEND);
    assign out_last  = out_valid & (r_idx == w_last_idx);
    assign out_data  = out_valid ? w_word[r_rp] : '0;
    assign busy      = |w_full;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_complex_result_reader.sv
// ============================================================================
// Module   : tb_complex_result_reader
// Brief    : Directed table-driven bench for complex_result_reader.
// Config   : COMPLEX_READER_ZERO_SKIP_EN selects the zero-skip expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_complex_result_reader;
    import complex_result_reader_pkg::*;

    localparam int EW = 64;
    localparam int NW = 8;

    typedef logic [NW-1:0][EW-1:0] words_t;

    typedef struct {
        words_t     w;
        logic [3:0] rpat;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              strb;
    logic [EW*NW-1:0]  rin;
    logic [EW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl [4];

    complex_result_reader #(.EW(EW), .N_WORDS(NW)) dut (
        .clk               (clk),
        .reset             (reset),
        .outsider_read_now (strb),
        .result_in         (rin),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .busy              (busy),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic words_t w8(input logic [63:0] a, b, c, d, e, f, g, h);
        w8[0] = a; w8[1] = b; w8[2] = c; w8[3] = d;
        w8[4] = e; w8[5] = f; w8[6] = g; w8[7] = h;
    endfunction

    // Word k sits at bits [EW*(NW-k)-1 -: EW] of the bus.
    function automatic logic [EW*NW-1:0] pack_vec(input words_t w);
        logic [EW*NW-1:0] v;
        for (int k = 0; k < NW; k++) v[EW*(NW-k)-1 -: EW] = w[k];
        return v;
    endfunction

    task automatic strobe(input words_t w);
        strb = 1'b1;
        rin  = pack_vec(w);
        tick();
        strb = 1'b0;
    endtask

    // strict: 0 = none, 1 = no gap after the first word, 2 = first word due now.
    task automatic expect_vec(input string name, input words_t exp, input int nexp,
                              input logic [3:0] rpat, input int strict);
        int         got = 0;
        bit         stalled = 1'b0;
        logic [63:0] held_d;
        logic       held_l;
        for (int cyc = 0; cyc < 100 && got < nexp; cyc++) begin
            out_ready = rpat[cyc % 4];
            if (stalled) begin
                check({name, " held_valid"}, 64'(out_valid), 64'd1);
                check({name, " held_data"}, out_data, held_d);
                check({name, " held_last"}, 64'(out_last), 64'(held_l));
            end
            if (strict == 2 || (strict == 1 && got > 0))
                check({name, " no_gap"}, 64'(out_valid), 64'd1);
            if (out_valid && out_ready) begin
                check($sformatf("%s word%0d", name, got), out_data, exp[got]);
                check($sformatf("%s last%0d", name, got), 64'(out_last), 64'(got == nexp - 1));
                got++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held_d  = out_data;
                held_l  = out_last;
            end
            tick();
        end
        check({name, " word_count"}, 64'(got), 64'(nexp));
    endtask

    initial begin
        words_t a, b, x, y, z, p, q, r, zv;
        bit     seen;
        cplx_word_t cw;

        reset = 1'b1; strb = 1'b0; out_ready = 1'b0; rin = '0;

        tbl[0].w = w8(64'h3f800000_00000000, 64'h3f800000_00000000, 64'h3f800000_00000000,
                      64'h3f800000_00000000, 64'h3f800000_00000000, 64'h3f800000_00000000,
                      64'h3f800000_00000000, 64'h3f800000_00000000);
        tbl[0].rpat = 4'b1111;
        tbl[1].w = w8(64'h3f800000_00000001, 64'h40000000_00000002, 64'h40400000_00000003,
                      64'h40800000_00000004, 64'h40a00000_00000005, 64'h40c00000_00000006,
                      64'h40e00000_00000007, 64'h41000000_00000008);
        tbl[1].rpat = 4'b0101;
        tbl[2].w = w8(64'hbf800000_3f800000, 64'h00000000_80000001, 64'h7f800000_ff800000,
                      64'h12345678_9abcdef0, 64'h80000000_00000000, 64'hdeadbeef_cafef00d,
                      64'h00000001_00000000, 64'hffffffff_ffffffff);
        tbl[2].rpat = 4'b0011;
        tbl[3].w = w8(64'h40400000_00000000, 64'h40400000_00000000, 64'h40400000_00000000,
                      64'h40400000_00000000, 64'h40400000_00000000, 64'h40400000_00000000,
                      64'h40400000_00000000, 64'h40400000_00000000);
        tbl[3].rpat = 4'b1001;

        // Reset state
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_data", out_data, 64'd0);

        // Capture-to-valid latency
        out_ready = 1'b1;
        strobe(tbl[0].w);
        check("lat_valid_n1", 64'(out_valid), 64'd0);
        check("lat_busy_n1", 64'(busy), 64'd1);
        tick();
        check("lat_valid_n2", 64'(out_valid), 64'd1);
        expect_vec("single", tbl[0].w, NW, 4'b1111, 2);
        check("single_busy_end", 64'(busy), 64'd0);

        // Table of vectors with varied backpressure
        for (int i = 0; i < 4; i++) begin
            strobe(tbl[i].w);
            expect_vec($sformatf("tbl%0d", i), tbl[i].w, NW, tbl[i].rpat, 0);
            check($sformatf("tbl%0d busy_end", i), 64'(busy), 64'd0);
            check($sformatf("tbl%0d valid_end", i), 64'(out_valid), 64'd0);
        end

        // Back-to-back vectors three cycles apart
        a = w8(64'h40000000_00000000, 64'h40000000_00000000, 64'h40000000_00000000,
               64'h40000000_00000000, 64'h40000000_00000000, 64'h40000000_00000000,
               64'h40000000_00000000, 64'h40000000_00000000);
        b = w8(64'h40400000_00000000, 64'h40400000_00000000, 64'h40400000_00000000,
               64'h40400000_00000000, 64'h40400000_00000000, 64'h40400000_00000000,
               64'h40400000_00000000, 64'h40400000_00000000);
        out_ready = 1'b1;
        fork
            begin strobe(a); tick(); tick(); strobe(b); end
            begin expect_vec("b2b_A", a, NW, 4'b1111, 1); expect_vec("b2b_B", b, NW, 4'b1111, 2); end
        join
        check("b2b_overflow", 64'(overflow), 64'd0);

        // Overflow: three strobes with the sink stalled
        x = tbl[1].w; y = tbl[2].w; z = tbl[3].w;
        out_ready = 1'b0;
        strobe(x);
        strobe(y);
        check("ovf_before", 64'(overflow), 64'd0);
        strobe(z);
        check("ovf_after", 64'(overflow), 64'd1);
        expect_vec("ovf_X", x, NW, 4'b1111, 0);
        expect_vec("ovf_Y", y, NW, 4'b1111, 0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("ovf_no_third", 64'(seen), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-drain, also clears the sticky overflow
        out_ready = 1'b1;
        strobe(tbl[1].w);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mid word%0d", k), out_data, tbl[1].w[k]);
            tick();
        end
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("mid_rst_residual", 64'(seen), 64'd0);

        // Capture landing on the slot freed by the final handshake
        p = tbl[0].w; q = tbl[2].w; r = tbl[3].w;
        out_ready = 1'b0;
        strobe(p);
        strobe(q);
        fork
            begin
                int c = 0;
                while (!(out_valid && out_last) && c < 40) begin tick(); c++; end
                check("simul_found_last", 64'(c < 40), 64'd1);
                strobe(r);
            end
            begin
                expect_vec("simul_P", p, NW, 4'b1111, 1);
                expect_vec("simul_Q", q, NW, 4'b1111, 2);
                expect_vec("simul_R", r, NW, 4'b1111, 2);
            end
        join
        check("simul_overflow", 64'(overflow), 64'd0);
        check("simul_busy_end", 64'(busy), 64'd0);

        // Zero words
        cw.re = 32'h3f800000; cw.im = 32'h00000000;
        zv = w8(64'd0, cw, 64'd0, 64'h00000000_bf800000, 64'd0, 64'd0, 64'h40400000_40400000, 64'd0);
        out_ready = 1'b1;
        strobe(zv);
`ifdef COMPLEX_READER_ZERO_SKIP_EN
        expect_vec("skip_sparse",
                   w8(cw, 64'h00000000_bf800000, 64'h40400000_40400000, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0),
                   3, 4'b1111, 0);
        strobe(w8(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0));
        expect_vec("skip_allzero", w8(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0),
                   1, 4'b1111, 0);
`else
        expect_vec("zero_sparse", zv, NW, 4'b1111, 0);
        strobe(w8(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0));
        expect_vec("zero_allzero", w8(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0),
                   NW, 4'b1111, 0);
`endif
        check("zero_busy_end", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
